// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit framer.
// Holds the framer state encodings, the default sync byte and the checksum fold.
// No logic of its own; no latency or backpressure.
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;

    // Frame-level sequencing: collect payload, then emit header, length, payload, checksum.
    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_HDR,
        ST_LEN,
        ST_PAYLOAD
`ifdef UART_FRAMER_CHECKSUM_EN
        ,
        ST_CSUM
`endif
    } top_state_t;

    // Per-byte handshake with the transmitter.
    typedef enum logic [1:0] {
        B_ISSUE,
        B_ACK,
        B_WAIT
    } byte_state_t;

    // Running 8-bit XOR checksum step.
    function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

endpackage

// File: rtl/sync_byte_fifo.sv
// Single-clock byte FIFO holding one frame's payload, first-word-fall-through.
// Latency: a written byte is visible on rd_data the cycle after the write.
// Backpressure: writes when full and reads when empty are ignored; full/empty report status.
module sync_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       clr,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       empty,
    output logic       full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_wr;
    logic          do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign rd_data = mem[rd_ptr];

    // Storage array; contents need no reset because count gates visibility.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    always_ff @(posedge clk) begin
        if (!resetn || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_framer.sv
// Frames a buffered payload as SYNC, LEN, payload[, XOR checksum] onto a UART byte handshake.
// Latency: first uart_tx_en one cycle after HDR entry; byte gap is transmitter turnaround + 2 cycles.
// Backpressure: in_ready drops while a frame transmits; byte issue stalls while uart_tx_busy is high.
// Build option: define UART_FRAMER_CHECKSUM_EN to append the checksum byte.
import uart_pkg::*;

module uart_tx_framer #(
    parameter int         DEPTH     = 16,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_last,
    output logic       in_ready,
    output logic       uart_tx_en,
    output logic [7:0] uart_tx_data,
    input  logic       uart_tx_busy,
    output logic       frame_busy,
    output logic       frame_done
);

    top_state_t  state, state_nx;
    byte_state_t bstate, bstate_nx;

    logic [7:0] len;
    logic [7:0] len_inc;
    logic [7:0] rem;
    logic [7:0] byte_val;
    logic [7:0] tx_data_nx;
    logic       tx_en_nx;
    logic       xfer;
    logic       frame_end;
    logic       frame_end_tx;
    logic       fifo_rd;
    logic [7:0] fifo_rd_data;
    logic       fifo_empty;
    logic       fifo_full;
    logic       unused_fifo_full;

`ifdef UART_FRAMER_CHECKSUM_EN
    logic [7:0] csum;
`endif

    assign xfer         = in_valid && in_ready;
    assign len_inc      = len + 8'd1;
    // A byte that fills the buffer closes the frame even without in_last.
    assign frame_end    = xfer && (in_last || (len_inc == 8'(DEPTH)));
    assign frame_end_tx = (state != ST_COLLECT) && (state_nx == ST_COLLECT);
    assign unused_fifo_full = fifo_full;

    sync_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .clr     (frame_end_tx),
        .wr_en   (xfer),
        .wr_data (in_data),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_data),
        .empty   (fifo_empty),
        .full    (fifo_full)
    );

    // Frame and byte state registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state  <= ST_COLLECT;
            bstate <= B_ISSUE;
        end else begin
            state  <= state_nx;
            bstate <= bstate_nx;
        end
    end

    // Next-state logic: byte handshake runs inside every transmit state.
    always_comb begin
        state_nx   = state;
        bstate_nx  = bstate;
        tx_en_nx   = 1'b0;
        tx_data_nx = uart_tx_data;
        fifo_rd    = 1'b0;
        byte_val   = 8'h00;

        case (state)
            ST_HDR:     byte_val = SYNC_BYTE;
            ST_LEN:     byte_val = len;
            ST_PAYLOAD: byte_val = fifo_rd_data;
`ifdef UART_FRAMER_CHECKSUM_EN
            ST_CSUM:    byte_val = csum;
`endif
            default:    byte_val = 8'h00;
        endcase

        if (state == ST_COLLECT) begin
            bstate_nx = B_ISSUE;
            if (frame_end) begin
                state_nx = ST_HDR;
            end
        end else begin
            case (bstate)
                B_ISSUE: begin
                    if (!uart_tx_busy && !((state == ST_PAYLOAD) && fifo_empty)) begin
                        tx_en_nx   = 1'b1;
                        tx_data_nx = byte_val;
                        fifo_rd    = (state == ST_PAYLOAD);
                        bstate_nx  = B_ACK;
                    end
                end
                B_ACK: begin
                    if (uart_tx_busy) begin
                        bstate_nx = B_WAIT;
                    end
                end
                B_WAIT: begin
                    if (!uart_tx_busy) begin
                        bstate_nx = B_ISSUE;
                        case (state)
                            ST_HDR:     state_nx = ST_LEN;
                            ST_LEN:     state_nx = ST_PAYLOAD;
                            ST_PAYLOAD: begin
                                if (rem == 8'd0) begin
`ifdef UART_FRAMER_CHECKSUM_EN
                                    state_nx = ST_CSUM;
`else
                                    state_nx = ST_COLLECT;
`endif
                                end
                            end
                            default:    state_nx = ST_COLLECT;
                        endcase
                    end
                end
                default: bstate_nx = B_ISSUE;
            endcase
        end
    end

    // Registered outputs; in_ready and frame_busy decode the upcoming state.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            uart_tx_en   <= 1'b0;
            uart_tx_data <= 8'h00;
            frame_busy   <= 1'b0;
            frame_done   <= 1'b0;
            in_ready     <= 1'b1;
        end else begin
            uart_tx_en   <= tx_en_nx;
            uart_tx_data <= tx_data_nx;
            frame_busy   <= (state_nx != ST_COLLECT);
            frame_done   <= frame_end_tx;
            in_ready     <= (state_nx == ST_COLLECT);
        end
    end

    // Payload length: counts accepted bytes, cleared as the frame completes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            len <= 8'd0;
        end else if (frame_end_tx) begin
            len <= 8'd0;
        end else if (xfer) begin
            len <= len_inc;
        end
    end

    // Payload bytes still to send; loaded with the final length when collection ends.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rem <= 8'd0;
        end else if (frame_end) begin
            rem <= len_inc;
        end else if (fifo_rd) begin
            rem <= rem - 8'd1;
        end
    end

`ifdef UART_FRAMER_CHECKSUM_EN
    // XOR of payload bytes, with the final length folded in as the frame closes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            csum <= 8'h00;
        end else if (frame_end_tx) begin
            csum <= 8'h00;
        end else if (frame_end) begin
            csum <= xor_fold(xor_fold(csum, in_data), len_inc);
        end else if (xfer) begin
            csum <= xor_fold(csum, in_data);
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_framer.sv
// Scoreboard bench for uart_tx_framer: stimulus pushes expected line bytes, monitor pops on each en/done.
// Transmitter model holds busy high for a fixed number of cycles per accepted byte.
// Checksum byte is expected only when UART_FRAMER_CHECKSUM_EN is defined.
module tb_uart_tx_framer;

    localparam int DEPTH  = 16;
    localparam int BUSY_N = 100;
    localparam int TMO    = 6000;

    logic       clk = 1'b0;
    logic       resetn;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       uart_tx_busy;
    logic       frame_busy;
    logic       frame_done;

    logic       model_busy = 1'b0;
    logic       stuck      = 1'b0;
    logic       prev_en    = 1'b0;
    int         busy_cnt   = 0;
    int         en_cnt     = 0;
    int         checks     = 0;
    int         passes     = 0;
    logic [8:0] exp_q[$];
    logic [8:0] mon_e;
    logic [7:0] pay [0:19];
    logic [7:0] ck_unused;

    always #5 clk = ~clk;

    assign uart_tx_busy = model_busy | stuck;

    uart_tx_framer #(
        .DEPTH     (DEPTH),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy),
        .frame_busy   (frame_busy),
        .frame_done   (frame_done)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        checks++;
        $display("FAIL %s: event not as expected", name);
    endtask

    // Expected line contents for one frame, followed by a frame_done marker.
    task automatic exp_frame(input int n, input logic [7:0] ck);
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, 8'(n)});
        for (int i = 0; i < n; i++) exp_q.push_back({1'b0, pay[i]});
`ifdef UART_FRAMER_CHECKSUM_EN
        exp_q.push_back({1'b0, ck});
`else
        ck_unused = ck;
`endif
        exp_q.push_back(9'h100);
    endtask

    // Called at a negedge; returns at the negedge after the byte is taken.
    task automatic send(input logic [7:0] d, input logic l);
        int t = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        while (!in_ready && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (t >= TMO) fail_now("send_timeout");
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!frame_done && t < TMO);
        if (!frame_done) fail_now("frame_done_timeout");
    endtask

    // Transmitter model and scoreboard monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (!resetn) begin
            model_busy = 1'b0;
            busy_cnt   = 0;
            prev_en    = 1'b0;
        end else begin
            if (uart_tx_en) begin
                en_cnt++;
                check("en_while_busy", 32'(uart_tx_busy), 0);
                check("en_back_to_back", 32'(prev_en), 0);
                check("in_ready_during_tx", 32'(in_ready), 0);
                if (exp_q.size() == 0) fail_now("unexpected_line_byte");
                else begin
                    mon_e = exp_q.pop_front();
                    check("line_byte", 32'({1'b0, uart_tx_data}), 32'(mon_e));
                end
                model_busy = 1'b1;
                busy_cnt   = BUSY_N;
            end else if (model_busy) begin
                busy_cnt--;
                if (busy_cnt == 0) model_busy = 1'b0;
            end
            prev_en = uart_tx_en;
            if (frame_done) begin
                if (exp_q.size() == 0) fail_now("unexpected_frame_done");
                else begin
                    mon_e = exp_q.pop_front();
                    check("frame_done_position", 32'h100, 32'(mon_e));
                end
            end
        end
    end

    initial begin
        int e0;
        int t;
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_uart_tx_en", 32'(uart_tx_en), 0);
        check("rst_uart_tx_data", 32'(uart_tx_data), 0);
        check("rst_frame_busy", 32'(frame_busy), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        resetn = 1'b1;
        @(negedge clk);

        // Three-byte frame: checksum 11^22^33^03 = 03.
        pay[0] = 8'h11; pay[1] = 8'h22; pay[2] = 8'h33;
        exp_frame(3, 8'h03);
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        check("in_ready_after_last", 32'(in_ready), 0);
        wait_done();

        // Single byte FF: checksum FF^01 = FE.
        pay[0] = 8'hFF;
        exp_frame(1, 8'hFE);
        send(8'hFF, 1'b1);
        check("in_ready_after_single", 32'(in_ready), 0);
        check("frame_busy_after_single", 32'(frame_busy), 1);
        wait_done();
        check("in_ready_at_done", 32'(in_ready), 1);
        check("frame_busy_at_done", 32'(frame_busy), 0);

        // 20 bytes without last: truncated 16-byte frame, rest start the next frame.
        for (int i = 0; i < 16; i++) pay[i] = 8'(i + 1);
        exp_frame(16, 8'h00);
        for (int i = 0; i < 5; i++) pay[i] = 8'(i + 17);
        exp_frame(5, 8'h14);
        for (int i = 1; i <= 16; i++) send(8'(i), 1'b0);
        check("in_ready_after_truncate", 32'(in_ready), 0);
        for (int i = 17; i <= 20; i++) send(8'(i), 1'b0);
        send(8'h15, 1'b1);
        wait_done();

        // Transmitter busy stuck at HDR entry: no en until it falls.
        stuck = 1'b1;
        pay[0] = 8'h5A;
        exp_frame(1, 8'h5B);
        send(8'h5A, 1'b1);
        e0 = en_cnt;
        repeat (50) @(negedge clk);
        check("no_en_while_stuck", 32'(en_cnt), 32'(e0));
        stuck = 1'b0;
        wait_done();

        // Reset during payload of a 5-byte frame.
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, 8'h05});
        exp_q.push_back({1'b0, 8'h31});
        e0 = en_cnt;
        for (int i = 0; i < 5; i++) send(8'(8'h31 + i), (i == 4));
        t = 0;
        while (en_cnt < e0 + 3 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        if (en_cnt < e0 + 3) fail_now("payload_start_timeout");
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_uart_tx_en", 32'(uart_tx_en), 0);
        check("midrst_uart_tx_data", 32'(uart_tx_data), 0);
        check("midrst_frame_busy", 32'(frame_busy), 0);
        check("midrst_frame_done", 32'(frame_done), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_queue_drained", 32'(exp_q.size()), 0);
        resetn = 1'b1;
        @(negedge clk);
        pay[0] = 8'h41; pay[1] = 8'h42;
        exp_frame(2, 8'h01);
        send(8'h41, 1'b0);
        send(8'h42, 1'b1);
        wait_done();

        // Two-byte frame: checksum 11^22^02 = 31.
        pay[0] = 8'h11; pay[1] = 8'h22;
        exp_frame(2, 8'h31);
        send(8'h11, 1'b0);
        send(8'h22, 1'b1);
        wait_done();

        repeat (20) @(negedge clk);
        check("all_expected_seen", 32'(exp_q.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
